// File: rtl/instr_load_ctrl_pkg.sv
// Shared types for the instruction loader: bus widths and loader FSM states.
package instr_load_ctrl_pkg;

    typedef logic [31:0] WORD;
    typedef logic [15:0] HALF_WORD;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } load_state_t;

endpackage

// File: rtl/instr_load_ctrl.sv
// Loads a length-prefixed half-word stream into instruction RAM and owns the
// RAM address port (and stalls the CPU) for the duration of the load.
module instr_load_ctrl
    import instr_load_ctrl_pkg::*;
#(
    parameter int MAX_HALFWORDS = 512,
    parameter int CNT_W         = $clog2(MAX_HALFWORDS) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_req_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic [31:0] cpu_fetch_addr_i,
    output logic [31:0] ram_addr_o,
    output logic [15:0] ram_data_o,
    output logic        ram_write_en_o,
    output logic        cpu_stall_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_HALFWORDS);

    load_state_t      state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    HALF_WORD         data_q, data_d;
    logic             err_q, err_d;

    logic     accept;
    HALF_WORD hdr_len;

    assign rx_ready_o = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                        (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI);
    assign accept     = rx_valid_i && rx_ready_o;
    assign hdr_len    = {rx_byte_i, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            ST_RUN: begin
                if (load_req_i) begin
                    state_d  = ST_LEN_LO;
                    err_d    = 1'b0;
                    wr_cnt_d = '0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_byte_i;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (hdr_len == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (hdr_len > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        len_d   = hdr_len[CNT_W-1:0];
                        state_d = ST_DATA_LO;
                    end
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    data_d[7:0] = rx_byte_i;
                    state_d     = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    data_d[15:8] = rx_byte_i;
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // wr_cnt stops at len, so the count can never wrap
                wr_cnt_d = wr_cnt_q + 1'b1;
                state_d  = (wr_cnt_d == len_q) ? ST_DONE : ST_DATA_LO;
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            len_lo_q <= '0;
            len_q    <= '0;
            wr_cnt_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Outside RUN the loader owns the port and presents the current write address
    assign ram_addr_o     = (state_q == ST_RUN) ? cpu_fetch_addr_i : WORD'({wr_cnt_q, 1'b0});
    assign ram_data_o     = data_q;
    assign ram_write_en_o = (state_q == ST_WRITE);
    assign cpu_stall_o    = (state_q != ST_RUN);
    assign load_done_o    = (state_q == ST_DONE);
    assign load_err_o     = err_q;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Self-checking bench for instr_load_ctrl: directed header cases plus randomized
// payloads compared against an expected write list built from the stream format.
module tb_instr_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        load_req_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [31:0] cpu_fetch_addr_i = 32'h0;
    logic [31:0] ram_addr_o;
    logic [15:0] ram_data_o;
    logic        ram_write_en_o;
    logic        cpu_stall_o;
    logic        load_done_o;
    logic        load_err_o;

    instr_load_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .load_req_i       (load_req_i),
        .rx_byte_i        (rx_byte_i),
        .rx_valid_i       (rx_valid_i),
        .rx_ready_o       (rx_ready_o),
        .cpu_fetch_addr_i (cpu_fetch_addr_i),
        .ram_addr_o       (ram_addr_o),
        .ram_data_o       (ram_data_o),
        .ram_write_en_o   (ram_write_en_o),
        .cpu_stall_o      (cpu_stall_o),
        .load_done_o      (load_done_o),
        .load_err_o       (load_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int          done_cnt = 0;
    logic [15:0] exp_data [512];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    // Observed RAM writes and done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_write_en_o) wr_q.push_back('{ram_addr_o, ram_data_o});
        if (load_done_o) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        load_req_i = 1'b1;
        tick();
        load_req_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit req_in_gap);
        int n;
        rx_valid_i = 1'b0;
        for (int i = 0; i < gap; i++) begin
            load_req_i = req_in_gap && (i == 0);
            tick();
            load_req_i = 1'b0;
        end
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        n = 0;
        while (!rx_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            chk_cnt++;
            $display("FAIL send_byte: rx_ready_o never rose for byte %02h", b);
        end
        tick();
        rx_valid_i = 1'b0;
    endtask

    // Full load of n half-words from exp_data; checks writes, done pulse and stall release
    task automatic do_load(input int n, input int maxgap, input bit inject, input string tag);
        logic [15:0] len;
        int          inj_at;
        int          k;
        len    = 16'(n);
        inj_at = inject ? int'($urandom_range(2 * n + 1, 1)) : -1;
        wr_q.delete();
        done_cnt = 0;
        pulse_req();
        send_byte(len[7:0],  int'($urandom_range(maxgap, 0)), 1'b0);
        send_byte(len[15:8], int'($urandom_range(maxgap, 0)), inj_at == 1);
        for (int i = 0; i < n; i++) begin
            send_byte(exp_data[i][7:0],  int'($urandom_range(maxgap, 0)), inj_at == 2 * i + 2);
            send_byte(exp_data[i][15:8], int'($urandom_range(maxgap, 0)), inj_at == 2 * i + 3);
        end
        k = 0;
        while (!load_done_o && k < 10) begin
            tick();
            k++;
        end
        chk_cnt++;
        if (load_done_o !== 1'b1) $display("FAIL %s done: got %b want 1", tag, load_done_o);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (cpu_stall_o !== 1'b0) $display("FAIL %s stall_release: got %b want 0", tag, cpu_stall_o);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt !== 1) $display("FAIL %s done_count: got %0d want 1", tag, done_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (wr_q.size() !== n) $display("FAIL %s write_count: got %0d want %0d", tag, wr_q.size(), n);
        else pass_cnt++;
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk_cnt++;
            if (wr_q[i].addr !== 32'(2 * i) || wr_q[i].data !== exp_data[i])
                $display("FAIL %s write[%0d]: got %04h@%08h want %04h@%08h", tag, i,
                         wr_q[i].data, wr_q[i].addr, exp_data[i], 32'(2 * i));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        cpu_fetch_addr_i = 32'h0000_0040;
        #1;
        chk_cnt++;
        if ({rx_ready_o, ram_write_en_o, cpu_stall_o, load_done_o, load_err_o} !== 5'b0 ||
            ram_data_o !== 16'h0)
            $display("FAIL reset_outputs: got rdy=%b we=%b stall=%b done=%b err=%b data=%04h want all 0",
                     rx_ready_o, ram_write_en_o, cpu_stall_o, load_done_o, load_err_o, ram_data_o);
        else pass_cnt++;
        chk_cnt++;
        if (ram_addr_o !== 32'h0000_0040) $display("FAIL reset_addr: got %08h want 00000040", ram_addr_o);
        else pass_cnt++;
        rst_i = 1'b0;
        tick();
        cpu_fetch_addr_i = 32'h0000_1234;
        #1;
        chk_cnt++;
        if (ram_addr_o !== 32'h0000_1234) $display("FAIL run_addr_passthru: got %08h want 00001234", ram_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        wr_q.delete();
        done_cnt = 0;
        pulse_req();
        chk_cnt++;
        if (cpu_stall_o !== 1'b1) $display("FAIL basic_stall_start: got %b want 1", cpu_stall_o);
        else pass_cnt++;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        chk_cnt++;
        if (ram_write_en_o !== 1'b1 || ram_addr_o !== 32'h0 || ram_data_o !== 16'h1234)
            $display("FAIL basic_write0: got we=%b %04h@%08h want we=1 1234@00000000",
                     ram_write_en_o, ram_data_o, ram_addr_o);
        else pass_cnt++;
        send_byte(8'hCD, 0, 1'b0);
        send_byte(8'hAB, 0, 1'b0);
        chk_cnt++;
        if (ram_write_en_o !== 1'b1 || ram_addr_o !== 32'h2 || ram_data_o !== 16'hABCD)
            $display("FAIL basic_write1: got we=%b %04h@%08h want we=1 ABCD@00000002",
                     ram_write_en_o, ram_data_o, ram_addr_o);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (load_done_o !== 1'b1 || cpu_stall_o !== 1'b1)
            $display("FAIL basic_done: got done=%b stall=%b want 1 1", load_done_o, cpu_stall_o);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (load_done_o !== 1'b0 || cpu_stall_o !== 1'b0 || ram_addr_o !== cpu_fetch_addr_i)
            $display("FAIL basic_release: got done=%b stall=%b addr=%08h want 0 0 %08h",
                     load_done_o, cpu_stall_o, ram_addr_o, cpu_fetch_addr_i);
        else pass_cnt++;
        chk_cnt++;
        if (wr_q.size() !== 2 || done_cnt !== 1)
            $display("FAIL basic_counts: got writes=%0d dones=%0d want 2 1", wr_q.size(), done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        wr_q.delete();
        done_cnt = 0;
        pulse_req();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        chk_cnt++;
        if (load_done_o !== 1'b1 || ram_write_en_o !== 1'b0)
            $display("FAIL zero_len_done: got done=%b we=%b want 1 0", load_done_o, ram_write_en_o);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (cpu_stall_o !== 1'b0 || load_done_o !== 1'b0 || wr_q.size() !== 0)
            $display("FAIL zero_len_run: got stall=%b done=%b writes=%0d want 0 0 0",
                     cpu_stall_o, load_done_o, wr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_len_err();
        wr_q.delete();
        done_cnt = 0;
        pulse_req();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        chk_cnt++;
        if (load_err_o !== 1'b1 || cpu_stall_o !== 1'b0 || rx_ready_o !== 1'b0)
            $display("FAIL len_err_set: got err=%b stall=%b rdy=%b want 1 0 0",
                     load_err_o, cpu_stall_o, rx_ready_o);
        else pass_cnt++;
        rx_valid_i = 1'b1;
        rx_byte_i  = 8'h5A;
        repeat (3) tick();
        rx_valid_i = 1'b0;
        chk_cnt++;
        if (load_err_o !== 1'b1 || done_cnt !== 0 || wr_q.size() !== 0)
            $display("FAIL len_err_sticky: got err=%b dones=%0d writes=%0d want 1 0 0",
                     load_err_o, done_cnt, wr_q.size());
        else pass_cnt++;
        pulse_req();
        chk_cnt++;
        if (load_err_o !== 1'b0 || cpu_stall_o !== 1'b1)
            $display("FAIL len_err_clear: got err=%b stall=%b want 0 1", load_err_o, cpu_stall_o);
        else pass_cnt++;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        chk_cnt++;
        if (load_err_o !== 1'b0 || cpu_stall_o !== 1'b1)
            $display("FAIL len_max_ok: got err=%b stall=%b want 0 1", load_err_o, cpu_stall_o);
        else pass_cnt++;
        for (int i = 0; i < 512; i++) exp_data[i] = 16'($urandom);
        wr_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            send_byte(exp_data[i][7:0], 0, 1'b0);
            send_byte(exp_data[i][15:8], 0, 1'b0);
        end
        tick();
        tick();
        chk_cnt++;
        if (wr_q.size() !== 512 || done_cnt !== 1 || cpu_stall_o !== 1'b0)
            $display("FAIL len_max_load: got writes=%0d dones=%0d stall=%b want 512 1 0",
                     wr_q.size(), done_cnt, cpu_stall_o);
        else pass_cnt++;
        chk_cnt++;
        if (wr_q.size() == 512 && (wr_q[511].addr !== 32'h3FE || wr_q[511].data !== exp_data[511]))
            $display("FAIL len_max_last: got %04h@%08h want %04h@000003fe",
                     wr_q[511].data, wr_q[511].addr, exp_data[511]);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) exp_data[i] = 16'($urandom);
            cpu_fetch_addr_i = $urandom;
            do_load(n, 0, 1'b0, "nogap");
            do_load(n, 5, 1'b1, "gap_req");
        end
    endtask

    task automatic test_reset_mid();
        wr_q.delete();
        done_cnt = 0;
        pulse_req();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 1, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 2, 1'b0);
        rst_i = 1'b1;
        tick();
        chk_cnt++;
        if (cpu_stall_o !== 1'b0 || rx_ready_o !== 1'b0 || ram_write_en_o !== 1'b0 ||
            ram_data_o !== 16'h0 || ram_addr_o !== cpu_fetch_addr_i)
            $display("FAIL reset_mid_run: got stall=%b rdy=%b we=%b data=%04h addr=%08h want 0 0 0 0000 %08h",
                     cpu_stall_o, rx_ready_o, ram_write_en_o, ram_data_o, ram_addr_o, cpu_fetch_addr_i);
        else pass_cnt++;
        rst_i = 1'b0;
        rx_valid_i = 1'b1;
        rx_byte_i  = 8'h44;
        repeat (4) tick();
        rx_valid_i = 1'b0;
        chk_cnt++;
        if (wr_q.size() !== 1 || done_cnt !== 0 || cpu_stall_o !== 1'b0)
            $display("FAIL reset_mid_writes: got writes=%0d dones=%0d stall=%b want 1 0 0",
                     wr_q.size(), done_cnt, cpu_stall_o);
        else pass_cnt++;
        chk_cnt++;
        if (wr_q.size() > 0 && (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 16'h2211))
            $display("FAIL reset_mid_first: got %04h@%08h want 2211@00000000", wr_q[0].data, wr_q[0].addr);
        else pass_cnt++;
        exp_data[0] = 16'($urandom);
        do_load(1, 2, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_len_err();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
